instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Program-counter owner and instruction fetcher for the RISC core, sitting at the consuming end of the branch-control interface. It holds the PC, issues requests to instruction memory, presents the fetched instruction and its PC to decode (pc_in), and loads the next PC from branch control (next_pc) when decode accepts the instruction. A ready/valid handshake toward decode, a req/ack handshake toward memory, a halt path and a fetch-timeout error are included.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
MAX_WAIT, 16, maximum cycles imem_req may stay high without imem_ack before fetch_err; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
imem_req  output  1  instruction memory request.
imem_addr  output  32  word address of the request.
imem_ack  input  1  memory acknowledges; imem_rdata is valid in the same cycle.
imem_rdata  input  32  fetched instruction word.
instr  output  32  instruction presented to decode.
pc_in  output  32  PC of the presented instruction; feeds branch control.
instr_valid  output  1  instr/pc_in are valid.
instr_ready  input  1  decode accepts the presented instruction this cycle.
next_pc  input  32  next PC from branch control; sampled only on handshake.
halt_req  input  1  decode signals halt; sampled only on handshake.
halted  output  1  core halted.
fetch_err  output  1  memory timeout occurred.

Behaviour:
- All outputs are registered. While rst=0: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0, pc_in=RESET_PC, instr_valid=0, halted=0, fetch_err=0, wait_cnt=0.
- Reset assertion mid-operation aborts any outstanding request immediately. The ack of the aborted request is never consumed.
- States: IDLE, FETCH, VALID, HALT, ERR.
- IDLE: the first clock edge after rst deasserts moves to FETCH and sets imem_req=1, imem_addr=pc.
- FETCH:
  - imem_req stays 1 and imem_addr stays stable until ack.
  - On imem_ack: instr<=imem_rdata, pc_in<=pc, instr_valid<=1, imem_req<=0, wait_cnt<=0, go to VALID. Ack at edge n gives instr_valid=1 after edge n.
  - Otherwise wait_cnt increments. When MAX_WAIT!=0 and wait_cnt==MAX_WAIT-1 without ack: imem_req<=0, fetch_err<=1, go to ERR.
- VALID:
  - instr, pc_in and instr_valid are held stable while instr_ready=0.
  - On instr_ready=1 with halt_req=1: instr_valid<=0, halted<=1, go to HALT.
  - On instr_ready=1 with halt_req=0: pc<=next_pc, imem_addr<=next_pc, imem_req<=1, instr_valid<=0, go to FETCH. The request is issued on the cycle after the handshake.
  - Steady-state throughput with a zero-wait memory is one instruction per 2 cycles.
- HALT and ERR: terminal until reset; imem_req=0, instr_valid=0. halted or fetch_err respectively stays 1.
- imem_ack while imem_req=0 is ignored.
- instr_ready while instr_valid=0 is ignored.
- halt_req and next_pc are don't-care outside a handshake.
- next_pc is used unmodified. The sequential +1 and 32-bit wrap (0xFFFFFFFF -> 0) are branch control's responsibility; the fetch unit must pass 0 through correctly.
- Acks are not counted twice. There is exactly one outstanding request at a time.

Test Plan:
- Reset then release, with memory acking on the first req cycle returning 0xAAAA0001 -> imem_addr=0 with req high for 1 cycle; instr=0xAAAA0001, pc_in=0, valid=1 next cycle.
- instr_ready held 0 for 5 cycles while imem_ack pulses spuriously -> instr and pc_in unchanged, no new req. Then ready=1 with next_pc=0x40 -> req with addr=0x40 on the following cycle.
- Redirect sequence: next_pc values 1, 2, 0x100 (taken branch), 0x101 -> imem_addr follows exactly that sequence; pc_in matches each presented instr.
- Memory never acks, MAX_WAIT=16 -> fetch_err=1 after exactly 16 req-high cycles, req drops, state stays ERR until rst.
- Handshake with halt_req=1 -> halted=1, no further req. rst pulse low -> all outputs return to reset values and fetch restarts at RESET_PC.
- rst asserted while req high awaiting ack -> req=0 asynchronously. An ack arriving during reset does not produce instr_valid after release.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction fetcher with a ready/valid path to decode and a req/ack path to memory.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_in,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [31:0] next_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        fetch_err
);
    typedef enum logic [2:0] {IDLE, FETCH, VALID, HALT, ERR} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, addr_nx, instr_nx, pc_in_nx, wait_cnt, cnt_nx;
    logic        req_nx, valid_nx, halted_nx, err_nx, timeout;

    assign timeout = (MAX_WAIT != 0) && (wait_cnt == 32'(MAX_WAIT - 1));

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        addr_nx   = imem_addr;
        req_nx    = imem_req;
        instr_nx  = instr;
        pc_in_nx  = pc_in;
        valid_nx  = instr_valid;
        halted_nx = halted;
        err_nx    = fetch_err;
        cnt_nx    = wait_cnt;
        case (state)
            IDLE: begin
                state_nx = FETCH;
                req_nx   = 1'b1;
                addr_nx  = pc;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_nx = imem_rdata;
                    pc_in_nx = pc;
                    valid_nx = 1'b1;
                    req_nx   = 1'b0;
                    cnt_nx   = '0;
                    state_nx = VALID;
                end else if (timeout) begin
                    req_nx   = 1'b0;
                    err_nx   = 1'b1;
                    state_nx = ERR;
                end else begin
                    cnt_nx = wait_cnt + 32'd1;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    valid_nx  = 1'b0;
                    halted_nx = halt_req;
                    state_nx  = halt_req ? HALT : FETCH;
                    pc_nx     = halt_req ? pc : next_pc;
                    addr_nx   = halt_req ? imem_addr : next_pc;
                    req_nx    = !halt_req;
                end
            end
            default: ;
        endcase
    end

    // Reset also kills any outstanding request, so a late ack is never consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= '0;
            pc_in       <= RESET_PC;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            imem_req    <= req_nx;
            imem_addr   <= addr_nx;
            instr       <= instr_nx;
            pc_in       <= pc_in_nx;
            instr_valid <= valid_nx;
            halted      <= halted_nx;
            fetch_err   <= err_nx;
            wait_cnt    <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench; fetched words are queued on ack and checked when presented to decode.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] instr, pc_in, next_pc = '0;
    logic        instr_valid, instr_ready = 1'b0, halt_req = 1'b0, halted, fetch_err;

    typedef struct {logic [31:0] word; logic [31:0] pc;} exp_t;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    instr_fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .pc_in(pc_in),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .next_pc(next_pc),
        .halt_req(halt_req), .halted(halted), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_pc_in"}, pc_in, 32'h0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_seen"}, {31'd0, imem_req}, 32'd1);
    endtask

    // Serve one request after lat idle cycles, then check the presented instruction.
    task automatic fetch_one(input string tag, input logic [31:0] addr, input logic [31:0] word, input int lat);
        exp_t e;
        wait_req(tag);
        chk({tag, "_addr"}, imem_addr, addr);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk({tag, "_hold_addr"}, {imem_addr[30:0], imem_req}, {addr[30:0], 1'b1});
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        sb.push_back('{word, addr});
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_req_drop"}, {31'd0, imem_req}, 32'd0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_instr"}, instr, e.word);
            chk({tag, "_pc_in"}, pc_in, e.pc);
        end else chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    endtask

    task automatic accept(input string tag, input logic [31:0] npc, input logic halt);
        instr_ready = 1'b1;
        next_pc = npc;
        halt_req = halt;
        @(negedge clk);
        instr_ready = 1'b0;
        halt_req = 1'b0;
        next_pc = $urandom;
        chk({tag, "_valid_drop"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, !halt});
        if (!halt) chk({tag, "_next_addr"}, imem_addr, npc);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst0");
        rst = 1'b1;
        @(negedge clk);
        fetch_one("first", 32'h0, 32'hAAAA_0001, 0);

        for (int i = 0; i < 5; i++) begin
            imem_ack = i[0];
            imem_rdata = 32'hDEAD_0000 | 32'(i);
            @(negedge clk);
            chk("stall_instr", instr, 32'hAAAA_0001);
            chk("stall_pc", pc_in, 32'h0);
            chk("stall_req", {30'd0, imem_req, instr_valid}, 32'd1);
        end
        imem_ack = 1'b0;
        accept("acc40", 32'h40, 1'b0);

        fetch_one("f40", 32'h40, 32'h1111_0040, 0);
        accept("acc1", 32'h1, 1'b0);
        fetch_one("f1", 32'h1, 32'h2222_0001, 1);
        accept("acc2", 32'h2, 1'b0);
        fetch_one("f2", 32'h2, 32'h3333_0002, 0);
        accept("acc100", 32'h100, 1'b0);
        fetch_one("f100", 32'h100, 32'h4444_0100, 2);
        accept("acc101", 32'h101, 1'b0);
        fetch_one("f101", 32'h101, 32'h5555_0101, 0);
        accept("accwrap", 32'h0, 1'b0);
        fetch_one("fwrap", 32'h0, 32'h6666_0000, 3);

        accept("halt", 32'h77, 1'b1);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            @(negedge clk);
            chk("halted_state", {29'd0, halted, imem_req, instr_valid}, 32'b100);
        end
        imem_ack = 1'b0;

        rst = 1'b0;
        #1;
        chk_reset_outputs("rst1");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fetch_one("restart", 32'h0, 32'h7777_0000, 0);
        accept("acc_to", 32'h200, 1'b0);

        n = 0;
        while (imem_req && n < 100) begin
            chk("to_addr", imem_addr, 32'h200);
            @(negedge clk);
            n++;
        end
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_err", {30'd0, fetch_err, imem_req}, 32'b10);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            @(negedge clk);
            chk("err_hold", {29'd0, fetch_err, imem_req, instr_valid}, 32'b100);
        end
        imem_ack = 1'b0;

        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fetch_one("post_err", 32'h0, 32'h8888_0000, 0);
        accept("acc_abort", 32'h300, 1'b0);
        wait_req("abort");
        #2 rst = 1'b0;
        #1 chk("abort_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("abort_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("release_valid", {30'd0, instr_valid, imem_req}, 32'b01);
        chk("release_addr", imem_addr, 32'h0);
        fetch_one("post_abort", 32'h0, 32'h9999_0000, 1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
